// File: rtl/scan_counter_n.sv
// scan_counter_n: parametrised digit-scan counter for a seven-segment bank.
//
// Counts 0..LAST up or down, advancing once every PRESCALE enabled clock
// cycles, and drives an active-low one-hot digit select from the registered
// count. A synchronous load overrides stepping. tick pulses for one cycle
// whenever the counter shows a newly stepped value; wrap pulses with tick
// when that step crossed the LAST/0 boundary.
//
// Optional feature (macro SCAN_BLANK_EN): after every step or load, sel_n is
// held all ones for BLANK_CYCLES clocks before showing the new digit. Without
// the macro there is no blank timer and BLANK_CYCLES is ignored.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   en        count enable (gates the prescaler)
//   up        direction: 1 = increment, 0 = decrement
//   load      synchronous load request, wins over stepping
//   load_val  value to load; values above LAST load as 0
//   counter   registered count
//   sel_n     registered active-low one-hot decode of counter
//   tick      one-cycle step strobe
//   wrap      one-cycle wrap strobe, coincident with tick
module scan_counter_n #(
  parameter int unsigned WIDTH        = 2,
  parameter int unsigned LAST         = 3,
  parameter int unsigned PRESCALE     = 1,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic [LAST:0]    sel_n,
  output logic             tick,
  output logic             wrap
);

  localparam int unsigned    PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PreMax  = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CntLast = WIDTH'(LAST);

  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [LAST:0]    sel_n_q, sel_n_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             step;
  logic [LAST:0]    decode;

  // Prescaler, load and step next-state.
  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    step   = 1'b0;
    if (load) begin
      pre_d = '0;
      // Widen before comparing so a full-range LAST does not fold to a constant.
      cnt_d = (32'(load_val) <= LAST) ? load_val : '0;
    end else if (en) begin
      if (pre_q == PreMax) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    if (step) begin
      tick_d = 1'b1;
      if (up) begin
        if (cnt_q == CntLast) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d  = CntLast;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // Decode the next count so sel_n is registered alongside counter.
  always_comb begin
    decode = '1;
    for (int unsigned i = 0; i <= LAST; i++) begin
      if (cnt_d == WIDTH'(i)) begin
        decode[i] = 1'b0;
      end
    end
  end

`ifdef SCAN_BLANK_EN
  localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);

  logic [BW-1:0] blank_q, blank_d;

  // Timer reloads on every step/load and runs down regardless of en; the
  // select stays dark while the next timer value is non-zero.
  always_comb begin
    blank_d = blank_q;
    if (step || load) begin
      blank_d = BW'(BLANK_CYCLES);
    end else if (blank_q != '0) begin
      blank_d = blank_q - BW'(1);
    end
    sel_n_d = (blank_d != '0) ? '1 : decode;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end
`else
  always_comb begin
    sel_n_d = decode;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q      <= '0;
      cnt_q      <= '0;
      sel_n_q    <= '1;
      sel_n_q[0] <= 1'b0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      sel_n_q <= sel_n_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign counter = cnt_q;
  assign sel_n   = sel_n_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_counter_n.sv
// Directed bench for scan_counter_n. Three instances share clock and inputs:
//   u_a: WIDTH=2 LAST=3 PRESCALE=4
//   u_b: WIDTH=2 LAST=2 PRESCALE=1
//   u_c: WIDTH=2 LAST=3 PRESCALE=1 (legacy 2-bit digit counter shape)
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_scan_counter_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [1:0] load_val;

  logic [1:0] a_counter, b_counter, c_counter;
  logic [3:0] a_sel_n, c_sel_n;
  logic [2:0] b_sel_n;
  logic       a_tick, a_wrap, b_tick, b_wrap, c_tick, c_wrap;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scan_counter_n #(.WIDTH(2), .LAST(3), .PRESCALE(4), .BLANK_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .counter(a_counter), .sel_n(a_sel_n), .tick(a_tick), .wrap(a_wrap)
  );

  scan_counter_n #(.WIDTH(2), .LAST(2), .PRESCALE(1), .BLANK_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .counter(b_counter), .sel_n(b_sel_n), .tick(b_tick), .wrap(b_wrap)
  );

  scan_counter_n #(.WIDTH(2), .LAST(3), .PRESCALE(1), .BLANK_CYCLES(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .counter(c_counter), .sel_n(c_sel_n), .tick(c_tick), .wrap(c_wrap)
  );

  function automatic logic [3:0] dec4(int c);
    logic [3:0] one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic logic [2:0] dec3(int c);
    logic [2:0] one = 3'b001;
    return ~(one << c);
  endfunction

  // Leaves the bench just after a falling edge with rst released, en=0.
  task automatic do_reset;
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 2'd0;
    @(negedge clk);
    tests++;
    if ({a_counter, a_sel_n, a_tick, a_wrap} !== {2'd0, 4'b1110, 2'b00}) begin
      fails++;
      $display("FAIL reset_held: got cnt=%0d sel=%b t=%b w=%b, want cnt=0 sel=1110 t=0 w=0",
               a_counter, a_sel_n, a_tick, a_wrap);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({a_counter, a_sel_n, a_tick, a_wrap} !== {2'd0, 4'b1110, 2'b00}) begin
      fails++;
      $display("FAIL reset_release: got cnt=%0d sel=%b t=%b w=%b, want cnt=0 sel=1110 t=0 w=0",
               a_counter, a_sel_n, a_tick, a_wrap);
    end
    en = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({a_counter, a_tick} !== {2'd1, 1'b1}) begin
      fails++;
      $display("FAIL reset_first_step: got cnt=%0d t=%b, want cnt=1 t=1", a_counter, a_tick);
    end
    // Reset between clock edges must take effect without an edge.
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({a_counter, a_sel_n, a_tick, a_wrap} !== {2'd0, 4'b1110, 2'b00}) begin
      fails++;
      $display("FAIL reset_async: got cnt=%0d sel=%b t=%b w=%b, want cnt=0 sel=1110 t=0 w=0",
               a_counter, a_sel_n, a_tick, a_wrap);
    end
    @(negedge clk);
    rst = 1'b1;
    // Partial prescale was discarded: the next step needs four full cycles.
    repeat (3) @(negedge clk);
    tests++;
    if ({a_counter, a_tick} !== {2'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_discard_hold: got cnt=%0d t=%b, want cnt=0 t=0", a_counter, a_tick);
    end
    @(negedge clk);
    tests++;
    if ({a_counter, a_tick} !== {2'd1, 1'b1}) begin
      fails++;
      $display("FAIL reset_discard_step: got cnt=%0d t=%b, want cnt=1 t=1", a_counter, a_tick);
    end
  endtask

  task automatic test_up_count;
    int ticks = 0;
    int wraps = 0;
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      int         ec;
      logic       et, ew;
      @(negedge clk);
      ec = (k / 4) % 4;
      et = (k % 4 == 0);
      ew = (k == 16);
      if (a_tick === 1'b1) ticks++;
      if (a_wrap === 1'b1) wraps++;
      tests++;
      if ({a_counter, a_sel_n, a_tick, a_wrap} !== {2'(ec), dec4(ec), et, ew}) begin
        fails++;
        $display("FAIL up_cycle%0d: got cnt=%0d sel=%b t=%b w=%b, want cnt=%0d sel=%b t=%b w=%b",
                 k, a_counter, a_sel_n, a_tick, a_wrap, ec, dec4(ec), et, ew);
      end
    end
    tests++;
    if (ticks != 4 || wraps != 1) begin
      fails++;
      $display("FAIL up_pulse_count: got ticks=%0d wraps=%0d, want ticks=4 wraps=1", ticks, wraps);
    end
  endtask

  task automatic test_down_odd_last;
    do_reset();
    en = 1'b1; up = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      int   ec;
      logic ew;
      @(negedge clk);
      ec = (3 - (k % 3)) % 3;
      ew = (k % 3 == 1);
      tests++;
      if ({b_counter, b_sel_n, b_tick, b_wrap} !== {2'(ec), dec3(ec), 1'b1, ew}) begin
        fails++;
        $display("FAIL down_cycle%0d: got cnt=%0d sel=%b t=%b w=%b, want cnt=%0d sel=%b t=1 w=%b",
                 k, b_counter, b_sel_n, b_tick, b_wrap, ec, dec3(ec), ew);
      end
    end
    // Counter is now 1; reversing takes effect on the very next step.
    up = 1'b1;
    @(negedge clk);
    tests++;
    if ({b_counter, b_wrap} !== {2'd2, 1'b0}) begin
      fails++;
      $display("FAIL dir_change_step: got cnt=%0d w=%b, want cnt=2 w=0", b_counter, b_wrap);
    end
    @(negedge clk);
    tests++;
    if ({b_counter, b_wrap} !== {2'd0, 1'b1}) begin
      fails++;
      $display("FAIL dir_change_wrap: got cnt=%0d w=%b, want cnt=0 w=1", b_counter, b_wrap);
    end
  endtask

  task automatic test_legacy;
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      int   ec;
      logic ew;
      @(negedge clk);
      ec = k % 4;
      ew = (k % 4 == 0);
      tests++;
      if ({c_counter, c_sel_n, c_tick, c_wrap} !== {2'(ec), dec4(ec), 1'b1, ew}) begin
        fails++;
        $display("FAIL legacy_cycle%0d: got cnt=%0d sel=%b t=%b w=%b, want cnt=%0d sel=%b t=1 w=%b",
                 k, c_counter, c_sel_n, c_tick, c_wrap, ec, dec4(ec), ew);
      end
    end
  endtask

  task automatic test_enable;
    logic en_v   [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic tick_v [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    up = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [1:0] ec;
      en = en_v[k];
      @(negedge clk);
      ec = tick_v[k] ? 2'd1 : 2'd0;
      tests++;
      if ({a_counter, a_tick} !== {ec, tick_v[k]}) begin
        fails++;
        $display("FAIL enable_cycle%0d: got cnt=%0d t=%b, want cnt=%0d t=%b",
                 k, a_counter, a_tick, ec, tick_v[k]);
      end
    end
  endtask

  task automatic test_load;
    do_reset();
    en = 1'b1; up = 1'b1;
    repeat (3) @(negedge clk);
    // Prescaler is at its terminal value: load must beat the step.
    load = 1'b1; load_val = 2'd2;
    @(negedge clk);
    tests++;
    if ({a_counter, a_tick, a_wrap, a_sel_n} !== {2'd2, 1'b0, 1'b0, 4'b1011}) begin
      fails++;
      $display("FAIL load_terminal: got cnt=%0d t=%b w=%b sel=%b, want cnt=2 t=0 w=0 sel=1011",
               a_counter, a_tick, a_wrap, a_sel_n);
    end
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] ec;
      logic       et;
      @(negedge clk);
      et = (k == 4);
      ec = et ? 2'd3 : 2'd2;
      tests++;
      if ({a_counter, a_tick} !== {ec, et}) begin
        fails++;
        $display("FAIL load_after%0d: got cnt=%0d t=%b, want cnt=%0d t=%b",
                 k, a_counter, a_tick, ec, et);
      end
    end
    // Load mid-prescale must clear the partial count.
    repeat (2) @(negedge clk);
    load = 1'b1; load_val = 2'd1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({a_counter, a_tick} !== {2'd1, 1'b0}) begin
      fails++;
      $display("FAIL load_clears_pre_hold: got cnt=%0d t=%b, want cnt=1 t=0", a_counter, a_tick);
    end
    @(negedge clk);
    tests++;
    if ({a_counter, a_tick} !== {2'd2, 1'b1}) begin
      fails++;
      $display("FAIL load_clears_pre_step: got cnt=%0d t=%b, want cnt=2 t=1", a_counter, a_tick);
    end
    // Load works with en low; out-of-range value loads as 0 on LAST=2.
    en = 1'b0; load = 1'b1; load_val = 2'd1;
    @(negedge clk);
    tests++;
    if (b_counter !== 2'd1) begin
      fails++;
      $display("FAIL load_in_range: got cnt=%0d, want cnt=1", b_counter);
    end
    load_val = 2'd3;
    @(negedge clk);
    load = 1'b0;
    tests++;
    if ({b_counter, b_sel_n, a_counter} !== {2'd0, 3'b110, 2'd3}) begin
      fails++;
      $display("FAIL load_out_of_range: got b_cnt=%0d b_sel=%b a_cnt=%0d, want 0 110 3",
               b_counter, b_sel_n, a_counter);
    end
  endtask

`ifdef SCAN_BLANK_EN
  task automatic test_blank;
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      int         ea;
      logic [3:0] sa;
      @(negedge clk);
      ea = (k / 4) % 4;
      sa = (k >= 4 && (k % 4 == 0 || k % 4 == 1)) ? 4'b1111 : dec4(ea);
      tests++;
      if ({a_counter, a_sel_n} !== {2'(ea), sa}) begin
        fails++;
        $display("FAIL blank_pre4_cycle%0d: got cnt=%0d sel=%b, want cnt=%0d sel=%b",
                 k, a_counter, a_sel_n, ea, sa);
      end
      tests++;
      if ({c_counter, c_sel_n} !== {2'(k % 4), 4'b1111}) begin
        fails++;
        $display("FAIL blank_pre1_cycle%0d: got cnt=%0d sel=%b, want cnt=%0d sel=1111",
                 k, c_counter, c_sel_n, k % 4);
      end
    end
  endtask
`endif

  initial begin
    #50000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef SCAN_BLANK_EN
    test_blank();
`else
    test_up_count();
    test_down_odd_last();
    test_legacy();
    test_enable();
    test_load();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
